data_mem_pipe: RTL and testbench
================================

// Module: data_mem_pipe
// PURPOSE
//  Parametrised, latency-configurable data memory for the RV32 core's MEM stage.
//  Byte-addressed, little-endian; B/H/W loads and stores with sign/zero extension.
//  Valid/ready request handshake, one-cycle response pulse, fault flag.
//  Successor to the single-cycle DMem: adds wait states, alignment/range/size
//  checking and reset.
// PARAMETERS
//  WORD_LEN          32    data width in bits (multiple of 8, >=32)
//  ADDR_SIZE         32    request address width
//  DEPTH_BYTES       4096  memory size in bytes (power of two)
//  LATENCY           2     cycles from accept edge to respValid (>=1)
//  ALLOW_MISALIGNED  0     1: misaligned H/W accesses allowed; 0: they fault
// PORTS
//  clk        in   1          clock, rising edge
//  rstn       in   1          asynchronous reset, active low
//  reqValid   in   1          request present
//  reqReady   out  1          block can accept a request this cycle
//  reqWrite   in   1          1 = store, 0 = load
//  reqAddr    in   ADDR_SIZE  byte address
//  reqSize    in   3          funct3 code: 0 B, 1 H, 2 W, 4 BU, 5 HU
//  reqWData   in   WORD_LEN   store data, low bytes used
//  respValid  out  1          one-cycle pulse: access complete
//  respRData  out  WORD_LEN   extended load data; 0 for stores/faults
//  respFault  out  1          qualified by respValid: access rejected
// BEHAVIOUR
//  - Reset (rstn=0, async): state IDLE, respValid=0, respRData=0,
//    respFault=0, counter=0. reqReady=1 after reset. RAM not cleared.
//  - Accept = reqValid && reqReady at a clk edge. Addr, size, wdata and write
//    are latched. Later input changes have no effect.
//  - FSM IDLE -> (accept) BUSY -> (count==LATENCY-1) RESP -> IDLE.
//    With LATENCY=1, accept goes directly to RESP.
//  - reqReady = (state==IDLE) || (state==RESP).
//    An accept in RESP re-enters BUSY/RESP, giving a new response every
//    LATENCY cycles.
//  - respValid is high exactly while state==RESP, for 1 cycle. No backpressure.
//  - Stores commit on the edge entering RESP. Unused bytes are untouched.
//  - Loads read RAM on the edge entering RESP. They see every earlier committed
//    store.
//  - Faults are evaluated at accept. A fault suppresses the write, forces
//    respRData=0 and sets respFault=1. Fault causes:
//      reqSize in {3,6,7}; addr+bytes-1 >= DEPTH_BYTES (no wrap-around);
//      ALLOW_MISALIGNED=0 and (H: addr[0]!=0 | W: addr[1:0]!=0).
//  - Extension: B/H sign-extend to WORD_LEN; BU/HU zero-extend; W passes through.
//  - Reset asserted mid-access aborts it: an uncommitted store is lost and no
//    respValid is issued.
//  - The counter width is clog2(LATENCY)+1 and saturates at LATENCY-1.
// STRUCTURE
//  - defines.v (shared) holds FUNCT3_BYTE/HALF/WORD/BYTE_UNSIGNED/HALF_UNSIGNED,
//    WORD_LEN and ADDR_SIZE. No new constants are local to this file.
//  - Sub-module mem_load_align (combinational) takes the raw word, byte offset
//    and size, and produces the extended load data. It is reused by a future
//    cache.
//  - The RAM is a reg [7:0] array of DEPTH_BYTES; the FSM and counter live in
//    this file.
// TESTING
//  1 Reset: rstn=0 mid-BUSY on a SW to 0x10 -> respValid=0, no pulse; a later
//    LW 0x10 returns the old value.
//  2 LATENCY=2: SW 0x8 data 0xDEADBEEF, then LW 0x8 -> respValid 2 cycles after
//    each accept; rdata=0xDEADBEEF, fault=0.
//  3 SB 0x9 data 0x80, then LB 0x9 -> 0xFFFFFF80; LBU 0x9 -> 0x00000080;
//    LW 0x8 -> 0xDEAD80EF.
//  4 ALLOW_MISALIGNED=0: LH 0x3 -> fault=1, rdata=0; SW 0xFFE -> fault=1 and
//    memory unchanged; reqSize=3 -> fault=1.
//  5 LATENCY=1, reqValid held high for 4 back-to-back LWs -> respValid high
//    4 consecutive cycles, data in order.
//  6 Same-edge store then load, LATENCY=3: SH 0x20 data 0x1234, then LHU 0x20
//    accepted in RESP -> 0x00001234.

Source files
------------

// File: rtl/data_mem_pipe_pkg.sv
// rtl/data_mem_pipe_pkg.sv - shared constants and types for the MEM-stage data memory
package data_mem_pipe_pkg;

  localparam int DEF_WORD_LEN  = 32;
  localparam int DEF_ADDR_SIZE = 32;

  localparam logic [2:0] FUNCT3_BYTE          = 3'd0;
  localparam logic [2:0] FUNCT3_HALF          = 3'd1;
  localparam logic [2:0] FUNCT3_WORD          = 3'd2;
  localparam logic [2:0] FUNCT3_BYTE_UNSIGNED = 3'd4;
  localparam logic [2:0] FUNCT3_HALF_UNSIGNED = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Bytes touched by a funct3 access size; 0 marks an illegal code.
  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3)
      FUNCT3_BYTE, FUNCT3_BYTE_UNSIGNED: return 3'd1;
      FUNCT3_HALF, FUNCT3_HALF_UNSIGNED: return 3'd2;
      FUNCT3_WORD:                       return 3'd4;
      default:                           return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_pipe_load_align.sv
// rtl/data_mem_pipe_load_align.sv - selects and sign/zero-extends load data from a raw word
module data_mem_pipe_load_align
  import data_mem_pipe_pkg::*;
#(
  parameter int WORD_LEN = DEF_WORD_LEN,
  parameter int OFF_W    = 2
) (
  input  logic [WORD_LEN-1:0] raw,
  input  logic [OFF_W-1:0]    offset,
  input  logic [2:0]          size,
  output logic [WORD_LEN-1:0] data
);

  logic [WORD_LEN-1:0] shifted;

  // Bring the addressed byte to bit 0, then extend according to the access size.
  always_comb begin
    shifted = raw >> {offset, 3'b000};
    case (size)
      FUNCT3_BYTE:          data = {{(WORD_LEN-8){shifted[7]}}, shifted[7:0]};
      FUNCT3_HALF:          data = {{(WORD_LEN-16){shifted[15]}}, shifted[15:0]};
      FUNCT3_BYTE_UNSIGNED: data = {{(WORD_LEN-8){1'b0}}, shifted[7:0]};
      FUNCT3_HALF_UNSIGNED: data = {{(WORD_LEN-16){1'b0}}, shifted[15:0]};
      default:              data = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem_pipe.sv
// rtl/data_mem_pipe.sv - latency-configurable byte-addressed data memory for the MEM stage
module data_mem_pipe
  import data_mem_pipe_pkg::*;
#(
  parameter int WORD_LEN         = DEF_WORD_LEN,
  parameter int ADDR_SIZE        = DEF_ADDR_SIZE,
  parameter int DEPTH_BYTES      = 4096,
  parameter int LATENCY          = 2,
  parameter int ALLOW_MISALIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [ADDR_SIZE-1:0] reqAddr,
  input  logic [2:0]           reqSize,
  input  logic [WORD_LEN-1:0]  reqWData,
  output logic                 respValid,
  output logic [WORD_LEN-1:0]  respRData,
  output logic                 respFault
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = $clog2(LATENCY) + 1;
  localparam int WB = WORD_LEN / 8;
  localparam int OW = $clog2(WB);

  logic [7:0] ram [DEPTH_BYTES];

  state_t          state, next_state;
  logic [CW-1:0]   cnt, cnt_next;
  logic            accept;

  logic            lat_write, lat_fault;
  logic [AW-1:0]   lat_addr;
  logic [2:0]      lat_size;
  logic [WORD_LEN-1:0] lat_wdata;

  logic [2:0]      in_nbytes;
  logic [ADDR_SIZE:0] in_last;
  logic            in_fault;

  logic            op_from_inputs;
  logic            op_write, op_fault, commit_wr;
  logic [AW-1:0]   op_addr;
  logic [2:0]      op_size, op_nbytes;
  logic [WORD_LEN-1:0] op_wdata, raw_word, load_data;

  assign reqReady  = (state == ST_IDLE) || (state == ST_RESP);
  assign respValid = (state == ST_RESP);
  assign accept    = reqValid && reqReady;

  // Fault check on the incoming request; the end address is one bit wider so it cannot wrap.
  always_comb begin
    in_nbytes = size_bytes(reqSize);
    in_last   = {1'b0, reqAddr} + (ADDR_SIZE+1)'(in_nbytes) - (ADDR_SIZE+1)'(1);
    in_fault  = (in_nbytes == 3'd0)
             || (in_last >= (ADDR_SIZE+1)'(DEPTH_BYTES))
             || ((ALLOW_MISALIGNED == 0)
                 && (((in_nbytes == 3'd2) && reqAddr[0])
                  || ((in_nbytes == 3'd4) && (reqAddr[1:0] != 2'b00))));
  end

  // The access completing this edge comes from the latch, except with LATENCY=1 where it is the
  // request being accepted on the same edge.
  always_comb begin
    op_from_inputs = (state != ST_BUSY);
    op_write  = op_from_inputs ? reqWrite          : lat_write;
    op_fault  = op_from_inputs ? in_fault          : lat_fault;
    op_addr   = op_from_inputs ? reqAddr[AW-1:0]   : lat_addr;
    op_size   = op_from_inputs ? reqSize           : lat_size;
    op_wdata  = op_from_inputs ? reqWData          : lat_wdata;
    op_nbytes = size_bytes(op_size);
    commit_wr = rstn && (next_state == ST_RESP) && op_write && !op_fault;
  end

  // Gather the byte window starting at the access address, so misaligned accesses need no rotation.
  always_comb begin
    raw_word = '0;
    for (int k = 0; k < WB; k++) begin
      raw_word[8*k +: 8] = ram[op_addr + AW'(k)];
    end
  end

  data_mem_pipe_load_align #(
    .WORD_LEN (WORD_LEN),
    .OFF_W    (OW)
  ) u_load_align (
    .raw    (raw_word),
    .offset ('0),
    .size   (op_size),
    .data   (load_data)
  );

  // Next-state logic: accepts restart the wait from IDLE or RESP; BUSY counts up to LATENCY-1.
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            next_state = ST_RESP;
          end else begin
            next_state = ST_BUSY;
            cnt_next   = CW'(1);
          end
        end else begin
          next_state = ST_IDLE;
          cnt_next   = '0;
        end
      end
      ST_BUSY: begin
        if (cnt == CW'(LATENCY - 1)) begin
          next_state = ST_RESP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        next_state = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, request latch and response registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      respRData <= '0;
      respFault <= 1'b0;
      lat_write <= 1'b0;
      lat_fault <= 1'b0;
      lat_addr  <= '0;
      lat_size  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (accept) begin
        lat_write <= reqWrite;
        lat_fault <= in_fault;
        lat_addr  <= reqAddr[AW-1:0];
        lat_size  <= reqSize;
        lat_wdata <= reqWData;
      end
      if (next_state == ST_RESP) begin
        respFault <= op_fault;
        respRData <= (op_fault || op_write) ? '0 : load_data;
      end
    end
  end

  // Store commit on the edge entering RESP; bytes beyond the access size stay untouched.
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < op_nbytes) begin
          ram[op_addr + AW'(k)] <= op_wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb/tb_data_mem_pipe.sv - self-checking bench for data_mem_pipe at LATENCY 2, 1 and 3
module tb_data_mem_pipe;

  localparam int NI    = 3;
  localparam int DEPTH = 4096;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 3);
  endfunction

  function automatic int nbytes_of(input logic [2:0] s);
    if (s == 3'd0 || s == 3'd4) return 1;
    if (s == 3'd1 || s == 3'd5) return 2;
    return 4;
  endfunction

  logic        clk;
  logic        rstn;
  logic        req_valid [NI];
  logic        req_ready [NI];
  logic        req_write [NI];
  logic [31:0] req_addr  [NI];
  logic [2:0]  req_size  [NI];
  logic [31:0] req_wdata [NI];
  logic        resp_valid[NI];
  logic [31:0] resp_rdata[NI];
  logic        resp_fault[NI];

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    data_mem_pipe #(.LATENCY(lat_of(g))) u_dut (
      .clk       (clk),
      .rstn      (rstn),
      .reqValid  (req_valid[g]),
      .reqReady  (req_ready[g]),
      .reqWrite  (req_write[g]),
      .reqAddr   (req_addr[g]),
      .reqSize   (req_size[g]),
      .reqWData  (req_wdata[g]),
      .respValid (resp_valid[g]),
      .respRData (resp_rdata[g]),
      .respFault (resp_fault[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_n++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-instance byte store plus the single outstanding request.
  logic [7:0]  mdl_mem   [NI][DEPTH];
  bit          mdl_known [NI][DEPTH];
  bit          pend_v    [NI];
  int          pend_due  [NI];
  bit          pend_w    [NI];
  logic [31:0] pend_a    [NI];
  logic [2:0]  pend_s    [NI];
  logic [31:0] pend_d    [NI];

  function automatic void model_resp(input int i, output bit f, output logic [31:0] d,
                                     output bit known);
    longint a, v;
    int nb;
    logic [2:0] s;
    s  = pend_s[i];
    a  = pend_a[i];
    nb = nbytes_of(s);
    f  = !(s inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (a + nb - 1 >= DEPTH)
         || (nb > 1 && (a % nb) != 0);
    d = 32'h0;
    known = 1'b1;
    if (!f && !pend_w[i]) begin
      v = 0;
      for (int k = 0; k < nb; k++) begin
        if (!mdl_known[i][a+k]) known = 1'b0;
        v = v | (longint'(mdl_mem[i][a+k]) << (8*k));
      end
      if (s == 3'd0 && v >= 128)   v = v - 256;
      if (s == 3'd1 && v >= 32768) v = v - 65536;
      d = v[31:0];
    end
  endfunction

  // Compare process: every cycle, every instance, against the model.
  always @(negedge clk) begin : mon
    bit ev, ef, ek;
    logic [31:0] ed;
    for (int i = 0; i < NI; i++) begin
      if (!rstn) begin
        pend_v[i] = 1'b0;
        chk($sformatf("mon%0d_valid_in_reset", i), resp_valid[i], 1'b0);
      end else begin
        ev = pend_v[i] && (pend_due[i] == edge_n);
        chk($sformatf("mon%0d_valid", i), resp_valid[i], ev);
        if (ev) begin
          model_resp(i, ef, ed, ek);
          chk($sformatf("mon%0d_fault", i), resp_fault[i], ef);
          if (ek) chk($sformatf("mon%0d_rdata", i), resp_rdata[i], ed);
          if (pend_w[i] && !ef) begin
            for (int k = 0; k < nbytes_of(pend_s[i]); k++) begin
              mdl_mem[i][pend_a[i]+k]   = pend_d[i][8*k +: 8];
              mdl_known[i][pend_a[i]+k] = 1'b1;
            end
          end
          pend_v[i] = 1'b0;
        end
        if (req_valid[i] && req_ready[i]) begin
          pend_v[i]   = 1'b1;
          pend_due[i] = edge_n + lat_of(i);
          pend_w[i]   = req_write[i];
          pend_a[i]   = req_addr[i];
          pend_s[i]   = req_size[i];
          pend_d[i]   = req_wdata[i];
        end
      end
    end
  end

  // Present a request (caller is just after a rising edge); returns just after the accept edge.
  task automatic issue(input int i, input bit w, input logic [31:0] a, input logic [2:0] s,
                       input logic [31:0] d);
    req_write[i] = w;
    req_addr[i]  = a;
    req_size[i]  = s;
    req_wdata[i] = d;
    req_valid[i] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL issue_timeout inst %0d: reqReady stayed 0, required 1", i);
  endtask

  task automatic wait_resp(input int i, output int lat, output logic [31:0] rd, output logic f);
    lat = 0;
    rd  = 'x;
    f   = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (resp_valid[i]) begin
        lat = n;
        rd  = resp_rdata[i];
        f   = resp_fault[i];
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL resp_timeout inst %0d: respValid stayed 0, required 1", i);
  endtask

  task automatic do_op(input string name, input int i, input bit w, input logic [31:0] a,
                       input logic [2:0] s, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_f);
    int lat;
    logic [31:0] rd;
    logic f;
    @(posedge clk);
    #1;
    issue(i, w, a, s, d);
    req_valid[i] = 1'b0;
    wait_resp(i, lat, rd, f);
    chk({name, "_lat"}, lat, lat_of(i));
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_fault"}, f, exp_f);
  endtask

  initial begin : stim
    int lat;
    logic [31:0] rd;
    logic f;
    logic [31:0] burst_exp [4];
    burst_exp = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    rstn = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = '0;
      req_size[i]  = '0;
      req_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("reset_valid", resp_valid[i], 1'b0);
      chk("reset_rdata", resp_rdata[i], 32'h0);
      chk("reset_fault", resp_fault[i], 1'b0);
      chk("reset_ready", req_ready[i], 1'b1);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Reset mid-BUSY drops the store and its response.
    do_op("sw_old", 0, 1'b1, 32'h10, 3'd2, 32'h11223344, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    issue(0, 1'b1, 32'h10, 3'd2, 32'hAABBCCDD);
    req_valid[0] = 1'b0;
    rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_valid", resp_valid[0], 1'b0);
      chk("abort_ready", req_ready[0], 1'b1);
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_pulse", resp_valid[0], 1'b0);
    end
    do_op("lw_old", 0, 1'b0, 32'h10, 3'd2, 32'h0, 32'h11223344, 1'b0);

    // Word store/load and byte merge with extension.
    do_op("sw_8",  0, 1'b1, 32'h8, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0);
    do_op("lw_8",  0, 1'b0, 32'h8, 3'd2, 32'h0, 32'hDEADBEEF, 1'b0);
    do_op("sb_9",  0, 1'b1, 32'h9, 3'd0, 32'h00000080, 32'h0, 1'b0);
    do_op("lb_9",  0, 1'b0, 32'h9, 3'd0, 32'h0, 32'hFFFFFF80, 1'b0);
    do_op("lbu_9", 0, 1'b0, 32'h9, 3'd4, 32'h0, 32'h00000080, 1'b0);
    do_op("lw_8b", 0, 1'b0, 32'h8, 3'd2, 32'h0, 32'hDEAD80EF, 1'b0);
    do_op("lh_a",  0, 1'b0, 32'hA, 3'd1, 32'h0, 32'hFFFFDEAD, 1'b0);

    // Faults: misalignment, range, illegal size.
    do_op("lh_3",    0, 1'b0, 32'h3,    3'd1, 32'h0, 32'h0, 1'b1);
    do_op("sh_ffe",  0, 1'b1, 32'hFFE,  3'd1, 32'h00005555, 32'h0, 1'b0);
    do_op("sw_ffe",  0, 1'b1, 32'hFFE,  3'd2, 32'hCAFEF00D, 32'h0, 1'b1);
    do_op("lhu_ffe", 0, 1'b0, 32'hFFE,  3'd5, 32'h0, 32'h00005555, 1'b0);
    do_op("size3",   0, 1'b0, 32'h0,    3'd3, 32'h0, 32'h0, 1'b1);
    do_op("size7",   0, 1'b1, 32'h10,   3'd7, 32'h0, 32'h0, 1'b1);
    do_op("lb_1000", 0, 1'b0, 32'h1000, 3'd0, 32'h0, 32'h0, 1'b1);
    do_op("lw_10",   0, 1'b0, 32'h10,   3'd2, 32'h0, 32'h11223344, 1'b0);

    // LATENCY=1: back-to-back loads with reqValid held high.
    for (int k = 0; k < 4; k++) begin
      do_op("sw_burst", 1, 1'b1, 32'h40 + 4*k, 3'd2, burst_exp[k], 32'h0, 1'b0);
    end
    @(posedge clk);
    #1;
    req_write[1] = 1'b0;
    req_size[1]  = 3'd2;
    req_addr[1]  = 32'h40;
    req_valid[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      if (k < 3) req_addr[1] = 32'h40 + 4*(k+1);
      else       req_valid[1] = 1'b0;
      @(negedge clk);
      chk("burst_valid", resp_valid[1], 1'b1);
      chk("burst_rdata", resp_rdata[1], burst_exp[k]);
    end
    @(negedge clk);
    chk("burst_end", resp_valid[1], 1'b0);

    // LATENCY=3: load queued behind a store and accepted in RESP.
    @(posedge clk);
    #1;
    issue(2, 1'b1, 32'h20, 3'd1, 32'h00001234);
    req_write[2] = 1'b0;
    req_size[2]  = 3'd5;
    req_wdata[2] = 32'h0;
    @(negedge clk);
    chk("busy_not_ready", req_ready[2], 1'b0);
    wait_resp(2, lat, rd, f);
    chk("sh_20_lat", lat, 32'd2);
    chk("sh_20_fault", f, 1'b0);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    wait_resp(2, lat, rd, f);
    chk("lhu_20_lat", lat, 32'd3);
    chk("lhu_20_rdata", rd, 32'h00001234);
    chk("lhu_20_fault", f, 1'b0);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
